arb_job_requester: RTL and testbench
====================================

Name: arb_job_requester

Overview:
- Upstream stage of the token-ring arbitration path; one instance sits on the client side of each per-port controller.
- Replaces the random client model with real work: it buffers burst jobs from a producer in a small FIFO.
- For each job it raises req, waits for ack (i.e. token granted), streams the burst beats, drops req, then waits for ack release before requesting again.
- Keeps req/ack legal for the controller: req is held until ack rises and dropped only after the burst.

Parameters:
DEPTH, 4, job FIFO entries (power of two, >=2)
LEN_W, 4, width of burst-length field
DATA_W, 8, width of job payload

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
job_valid  input  1  producer offers a job this cycle
job_ready  output  1  FIFO can accept (count < DEPTH)
job_len  input  LEN_W  beats in job; 0 treated as 1
job_data  input  DATA_W  payload repeated on every beat
req  output  1  request to controller
ack  input  1  grant from controller
beat_valid  output  1  burst beat present this cycle
beat_data  output  DATA_W  head-job payload
beat_idx  output  LEN_W  beat index, 0-based
beat_last  output  1  final beat of current job
pending  output  log2(DEPTH)+1  jobs in FIFO, including the in-flight one
abort_err  output  1  sticky: ack dropped mid-burst

Behaviour:
- Reset, asynchronous:
  - state=IDLE; req=0; beat_valid=0; beat_idx=0; beat_last=0; abort_err=0.
  - FIFO emptied, pending=0.
  - Any burst in progress is discarded with no further beats.
- FIFO:
  - Push on job_valid&&job_ready; stored len = (job_len==0)?1:job_len.
  - job_ready=(pending<DEPTH) from registered count; no bypass when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop: pending unchanged.
  - Pointers wrap modulo DEPTH.
- States: IDLE, REQ, XFER, RELEASE (registered, one per cycle).
- IDLE:
  - If pending>0, next cycle req=1, state=REQ.
  - Otherwise stay; req=0.
- REQ:
  - req held 1.
  - On ack==1: state=XFER, beat_idx=0; the first beat appears the cycle after ack is sampled high.
  - No timeout; wait indefinitely.
- XFER:
  - beat_valid=1 every cycle; beat_data=head data; beat_last=(beat_idx==len-1).
  - beat_idx increments each beat.
  - On the last beat: pop head; next cycle req=0, beat_valid=0, state=RELEASE.
  - Exactly len beats per job, contiguous, no gaps.
- RELEASE:
  - req=0 until ack sampled 0, then state=IDLE.
  - Minimum one cycle in RELEASE even if ack is already 0.
- Back-to-back jobs: minimum req-low gap is 2 cycles (RELEASE, IDLE) before req rises again. This guarantees the controller sees !req and returns to its idle state.
- ack falls during XFER (protocol violation):
  - Stop beats immediately the next cycle; abort_err=1 (sticky until reset); req=0; state=RELEASE.
  - Head job is NOT popped and is retried in full.
- ack high while in IDLE: ignored; no beats generated.
- beat_idx width: LEN_W is sufficient since len<=2^LEN_W-1.

Decomposition:
- Shared package (alongside existing selection/controller_state/client_state enums):
  - requester_state enum {IDLE, REQ, XFER, RELEASE}.
  - Constants DEF_DEPTH=4, DEF_LEN_W=4, DEF_DATA_W=8.
- One sub-module: arb_job_fifo.
  - Parameterised DEPTH x (LEN_W+DATA_W) storage.
  - Handles push/pop/count, with asynchronous reset clearing pointers and count.
- FSM, beat counter and handshake stay in the top.

Test Plan:
- Single job: push len=3 data=0xA5; drive ack high 2 cycles after req rises, drop it 1 cycle after req falls. Expect:
  - req rises 1 cycle after push.
  - 3 beats 0xA5 with idx 0,1,2; beat_last only on idx 2.
  - req=0 the cycle after the last beat; pending returns 0.
- len=0: push job_len=0 -> exactly 1 beat with beat_last=1.
- Full FIFO: push 5 jobs back-to-back with ack held low.
  - job_ready=0 after the 4th push; 5th not accepted; pending=4.
  - Jobs then serviced in FIFO order with data intact.
- Back-to-back: 2 queued jobs (len=2 each) -> req low for exactly 2 cycles between bursts; 4 beats total.
- Mid-burst ack loss: len=4, ack falls after beat idx 1.
  - abort_err=1; beats stop; pending still 1.
  - On the next grant the job replays idx 0..3.
- Async reset asserted mid-XFER (between clock edges):
  - req, beat_valid and pending go 0 immediately.
  - After release, no activity until a new push.

Source files
------------

// File: rtl/arb_job_requester_pkg.sv
// Shared types and defaults for the token-ring arbitration path.
// Holds the existing selection/controller/client enums plus the job-requester
// state encoding and its default parameter values.
package arb_job_requester_pkg;

    localparam int unsigned DEF_DEPTH  = 4;
    localparam int unsigned DEF_LEN_W  = 4;
    localparam int unsigned DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_UPSTREAM,
        SEL_LOCAL
    } selection_e;

    typedef enum logic [1:0] {
        CTRL_IDLE,
        CTRL_GRANT,
        CTRL_PASS
    } controller_state_e;

    typedef enum logic [1:0] {
        CLI_IDLE,
        CLI_WAIT,
        CLI_BUSY
    } client_state_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        RELEASE
    } requester_state_e;

endpackage

// File: rtl/arb_job_requester_if.sv
// Bundle of the producer job port, controller req/ack handshake and beat output.
// master: the requester's view; slave: producer/controller/consumer view.
interface arb_job_requester_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              job_valid;
    logic              job_ready;
    logic [LEN_W-1:0]  job_len;
    logic [DATA_W-1:0] job_data;
    logic              req;
    logic              ack;
    logic              beat_valid;
    logic [DATA_W-1:0] beat_data;
    logic [LEN_W-1:0]  beat_idx;
    logic              beat_last;
    logic [CNT_W-1:0]  pending;
    logic              abort_err;

    modport master (
        input  job_valid, job_len, job_data, ack,
        output job_ready, req, beat_valid, beat_data, beat_idx, beat_last,
               pending, abort_err
    );

    modport slave (
        output job_valid, job_len, job_data, ack,
        input  job_ready, req, beat_valid, beat_data, beat_idx, beat_last,
               pending, abort_err
    );
endinterface

// File: rtl/arb_job_fifo.sv
// Job FIFO: DEPTH entries of W bits, registered count, power-of-two wrap.
// Ports: clk, reset (async high), push/wdata, pop, rdata (head), count, full.
// Caller guarantees push only when !full and pop only when count > 0.
module arb_job_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointer/count update; simultaneous push and pop leaves count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
endmodule

// File: rtl/arb_job_requester.sv
// Client-side job requester for one token-ring port controller.
// Buffers burst jobs, requests the token per job, streams len beats on grant,
// then releases and waits for ack low before requesting again.
// Ports: clk, reset (async high), bus (arb_job_requester_if.master).
module arb_job_requester
    import arb_job_requester_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned LEN_W  = DEF_LEN_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                 clk,
    input  logic                 reset,
    arb_job_requester_if.master  bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned JOB_W = LEN_W + DATA_W;

    requester_state_e  state_q, state_d;
    logic              req_q, req_d;
    logic              beat_valid_q, beat_valid_d;
    logic [LEN_W-1:0]  beat_idx_q, beat_idx_d;
    logic              beat_last_q, beat_last_d;
    logic              abort_err_q, abort_err_d;

    logic              push, pop, fifo_full;
    logic [LEN_W-1:0]  len_norm, head_len;
    logic [DATA_W-1:0] head_data;
    logic [JOB_W-1:0]  head_job;
    logic [CNT_W-1:0]  count;

    assign push     = bus.job_valid && !fifo_full;
    assign len_norm = (bus.job_len == '0) ? LEN_W'(1) : bus.job_len;

    arb_job_fifo #(
        .DEPTH (DEPTH),
        .W     (JOB_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({len_norm, bus.job_data}),
        .pop   (pop),
        .rdata (head_job),
        .count (count),
        .full  (fifo_full)
    );

    assign {head_len, head_data} = head_job;

    // Next-state: request per queued job, stream beats, release, repeat.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        beat_valid_d = 1'b0;
        beat_idx_d   = beat_idx_q;
        beat_last_d  = 1'b0;
        abort_err_d  = abort_err_q;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                req_d = 1'b0;
                if (count != '0) begin
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                req_d = 1'b1;
                if (bus.ack) begin
                    state_d      = XFER;
                    beat_valid_d = 1'b1;
                    beat_idx_d   = '0;
                    beat_last_d  = (head_len == LEN_W'(1));
                end
            end
            XFER: begin
                if (!bus.ack) begin
                    // Grant lost mid-burst: head stays queued and replays in full.
                    abort_err_d = 1'b1;
                    req_d       = 1'b0;
                    beat_idx_d  = '0;
                    state_d     = RELEASE;
                end else if (beat_last_q) begin
                    pop        = 1'b1;
                    req_d      = 1'b0;
                    beat_idx_d = '0;
                    state_d    = RELEASE;
                end else begin
                    beat_valid_d = 1'b1;
                    beat_idx_d   = beat_idx_q + LEN_W'(1);
                    beat_last_d  = ((beat_idx_q + LEN_W'(1)) == (head_len - LEN_W'(1)));
                end
            end
            RELEASE: begin
                req_d = 1'b0;
                if (!bus.ack) state_d = IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            beat_valid_q <= 1'b0;
            beat_idx_q   <= '0;
            beat_last_q  <= 1'b0;
            abort_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            beat_valid_q <= beat_valid_d;
            beat_idx_q   <= beat_idx_d;
            beat_last_q  <= beat_last_d;
            abort_err_q  <= abort_err_d;
        end
    end

    assign bus.job_ready  = !fifo_full;
    assign bus.req        = req_q;
    assign bus.beat_valid = beat_valid_q;
    assign bus.beat_data  = head_data;
    assign bus.beat_idx   = beat_idx_q;
    assign bus.beat_last  = beat_last_q;
    assign bus.pending    = count;
    assign bus.abort_err  = abort_err_q;
endmodule

// File: tb/tb_arb_job_requester.sv
// Self-checking bench for arb_job_requester: job table plus directed corner cases.
module tb_arb_job_requester;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    arb_job_requester_if #(.DEPTH(4), .LEN_W(4), .DATA_W(8)) bus ();

    arb_job_requester #(.DEPTH(4), .LEN_W(4), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] idx;
        logic       last;
    } beat_t;

    typedef struct {
        logic [3:0] len;
        logic [7:0] data;
        int         exp_beats;
    } vec_t;

    beat_t beat_q[$];
    vec_t  vecs[5];
    logic  ack_auto = 1'b0;
    int    req_low_cnt = 0;
    int    last_gap = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Beat recorder and req-low gap tracker, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.beat_valid)
                beat_q.push_back({bus.beat_data, bus.beat_idx, bus.beat_last});
            if (bus.req) begin
                if (req_low_cnt > 0) last_gap = req_low_cnt;
                req_low_cnt = 0;
            end else begin
                req_low_cnt = req_low_cnt + 1;
            end
        end
    end

    // Responsive controller: ack follows req one cycle later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ack_auto) bus.ack = bus.req;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_req(input logic level, input int max_cyc, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.req !== level && n < max_cyc);
        if (bus.req !== level) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting req=%0d after %0d cycles", name, level, n);
        end
    endtask

    task automatic wait_pending_zero(input int max_cyc, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.pending != 0 || bus.req) && n < max_cyc);
        chk({name, "_drain"}, int'(bus.pending), 0);
    endtask

    // Drive one job for exactly one cycle, starting at a negedge.
    task automatic push_job(input logic [3:0] len, input logic [7:0] data);
        bus.job_valid = 1'b1;
        bus.job_len   = len;
        bus.job_data  = data;
        @(negedge clk);
        bus.job_valid = 1'b0;
    endtask

    task automatic check_burst(input string name, input int start, input int len,
                               input logic [7:0] data);
        for (int i = 0; i < len; i++) begin
            chk({name, "_data"}, int'(beat_q[start+i].data), int'(data));
            chk({name, "_idx"},  int'(beat_q[start+i].idx), i);
            chk({name, "_last"}, int'(beat_q[start+i].last), (i == len - 1) ? 1 : 0);
        end
    endtask

    initial begin
        vecs[0] = '{len: 4'd3,  data: 8'hA5, exp_beats: 3};
        vecs[1] = '{len: 4'd0,  data: 8'h5A, exp_beats: 1};
        vecs[2] = '{len: 4'd1,  data: 8'hC3, exp_beats: 1};
        vecs[3] = '{len: 4'd15, data: 8'hF0, exp_beats: 15};
        vecs[4] = '{len: 4'd2,  data: 8'h3C, exp_beats: 2};

        reset         = 1'b1;
        bus.job_valid = 1'b0;
        bus.job_len   = '0;
        bus.job_data  = '0;
        bus.ack       = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_req",        int'(bus.req), 0);
        chk("rst_beat_valid", int'(bus.beat_valid), 0);
        chk("rst_beat_idx",   int'(bus.beat_idx), 0);
        chk("rst_beat_last",  int'(bus.beat_last), 0);
        chk("rst_abort",      int'(bus.abort_err), 0);
        chk("rst_pending",    int'(bus.pending), 0);
        chk("rst_job_ready",  int'(bus.job_ready), 1);

        // ack high while idle with nothing queued: ignored
        beat_q.delete();
        bus.ack = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_ack_req", int'(bus.req), 0);
        chk("idle_ack_beats", beat_q.size(), 0);
        bus.ack = 1'b0;
        repeat (2) @(negedge clk);

        // Single job with explicit ack timing
        beat_q.delete();
        push_job(4'd3, 8'hA5);
        chk("single_req_lo", int'(bus.req), 0);
        chk("single_pending", int'(bus.pending), 1);
        @(negedge clk);
        chk("single_req_rise", int'(bus.req), 1);
        @(negedge clk);
        bus.ack = 1'b1;
        wait_req(1'b0, 20, "single_req_fall");
        chk("single_bv_after", int'(bus.beat_valid), 0);
        chk("single_pending0", int'(bus.pending), 0);
        chk("single_nbeats", beat_q.size(), 3);
        if (beat_q.size() == 3) check_burst("single", 0, 3, 8'hA5);
        bus.ack = 1'b0;
        repeat (3) @(negedge clk);

        // Table-driven jobs with a responsive controller
        ack_auto = 1'b1;
        for (int v = 0; v < 5; v++) begin
            beat_q.delete();
            push_job(vecs[v].len, vecs[v].data);
            wait_req(1'b1, 10, "vec_req_rise");
            wait_req(1'b0, 40, "vec_req_fall");
            repeat (3) @(negedge clk);
            chk("vec_nbeats", beat_q.size(), vecs[v].exp_beats);
            if (beat_q.size() == vecs[v].exp_beats)
                check_burst("vec", 0, vecs[v].exp_beats, vecs[v].data);
            chk("vec_pending", int'(bus.pending), 0);
        end

        // Full FIFO: five back-to-back offers with ack held low
        ack_auto = 1'b0;
        bus.ack  = 1'b0;
        beat_q.delete();
        for (int j = 0; j < 5; j++) begin
            if (j == 4) chk("full_ready", int'(bus.job_ready), 0);
            bus.job_valid = 1'b1;
            bus.job_len   = 4'd1;
            bus.job_data  = 8'h31 + 8'(j);
            @(negedge clk);
        end
        bus.job_valid = 1'b0;
        chk("full_pending", int'(bus.pending), 4);
        ack_auto = 1'b1;
        wait_pending_zero(80, "full");
        repeat (3) @(negedge clk);
        chk("full_nbeats", beat_q.size(), 4);
        if (beat_q.size() == 4) begin
            check_burst("full_j0", 0, 1, 8'h31);
            check_burst("full_j1", 1, 1, 8'h32);
            check_burst("full_j2", 2, 1, 8'h33);
            check_burst("full_j3", 3, 1, 8'h34);
        end

        // Back-to-back: two len=2 jobs, req low exactly 2 cycles between bursts
        ack_auto = 1'b0;
        bus.ack  = 1'b0;
        beat_q.delete();
        push_job(4'd2, 8'h11);
        push_job(4'd2, 8'h22);
        wait_req(1'b1, 10, "b2b_req_rise");
        last_gap = 0;
        ack_auto = 1'b1;
        wait_pending_zero(60, "b2b");
        repeat (3) @(negedge clk);
        chk("b2b_gap", last_gap, 2);
        chk("b2b_nbeats", beat_q.size(), 4);
        if (beat_q.size() == 4) begin
            check_burst("b2b_j0", 0, 2, 8'h11);
            check_burst("b2b_j1", 2, 2, 8'h22);
        end

        // Mid-burst ack loss after beat idx 1, then full replay
        ack_auto = 1'b0;
        bus.ack  = 1'b0;
        beat_q.delete();
        push_job(4'd4, 8'h9C);
        wait_req(1'b1, 10, "abort_req_rise");
        bus.ack = 1'b1;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(bus.beat_valid && bus.beat_idx == 4'd1) && n < 20);
            chk("abort_reach_idx1", int'(bus.beat_idx), 1);
        end
        bus.ack = 1'b0;
        @(negedge clk);
        chk("abort_bv", int'(bus.beat_valid), 0);
        chk("abort_err", int'(bus.abort_err), 1);
        chk("abort_req", int'(bus.req), 0);
        chk("abort_pending", int'(bus.pending), 1);
        chk("abort_nbeats", beat_q.size(), 2);
        beat_q.delete();
        ack_auto = 1'b1;
        wait_pending_zero(40, "abort_replay");
        repeat (3) @(negedge clk);
        chk("abort_replay_nbeats", beat_q.size(), 4);
        if (beat_q.size() == 4) check_burst("abort_replay", 0, 4, 8'h9C);
        chk("abort_sticky", int'(bus.abort_err), 1);

        // Asynchronous reset between clock edges in the middle of a burst
        beat_q.delete();
        push_job(4'd8, 8'h77);
        begin
            int n = 0;
            while (!bus.beat_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("arst_in_xfer", int'(bus.beat_valid), 1);
        end
        #2 reset = 1'b1;
        #1;
        chk("arst_req", int'(bus.req), 0);
        chk("arst_bv", int'(bus.beat_valid), 0);
        chk("arst_pending", int'(bus.pending), 0);
        chk("arst_abort", int'(bus.abort_err), 0);
        @(negedge clk);
        reset = 1'b0;
        beat_q.delete();
        repeat (5) @(negedge clk);
        chk("arst_quiet_beats", beat_q.size(), 0);
        chk("arst_quiet_req", int'(bus.req), 0);
        push_job(4'd1, 8'hE1);
        wait_pending_zero(20, "arst_resume");
        repeat (3) @(negedge clk);
        chk("arst_resume_nbeats", beat_q.size(), 1);
        if (beat_q.size() == 1) check_burst("arst_resume", 0, 1, 8'hE1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
